// File: rtl/axi_stream_strip_pkg.sv
// Shared types and keep helpers for the AXI-Stream header stripper.
package axi_stream_strip_pkg;

    localparam int MAX_BYTES = 64;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        FIRST = S_FIRST,
        BODY  = S_BODY,
        FLUSH = S_FLUSH
    } state_e;

    // Top-aligned ones: the highest `count` bits of a `width`-bit keep field.
    function automatic logic [MAX_BYTES-1:0] keep_from_count(input int count, input int width);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < width && i + count >= width) k[i] = 1'b1;
        end
        return k;
    endfunction

    function automatic int keep_count(input logic [MAX_BYTES-1:0] keep);
        int c;
        c = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) c = c + 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/axi_stream_strip_header_aligner.sv
// Funnel shifter: merges the top-aligned residual with the current beat for strip length N.
module strip_byte_aligner
    import axi_stream_strip_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int LEN_WD  = 3
) (
    input  logic [DATA_WD-1:0] residual_i,
    input  logic [DATA_WD-1:0] beat_i,
    input  logic [LEN_WD-1:0]  len_i,
    output logic [DATA_WD-1:0] merged_o,
    output logic [DATA_WD-1:0] next_residual_o
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    // Residual holds R = DATA_BYTE_WD-N bytes at the top; the beat's top N bytes fill below it.
    always_comb begin
        merged_o        = residual_i | (beat_i >> (8 * (DATA_BYTE_WD - int'(len_i))));
        next_residual_o = beat_i << (8 * int'(len_i));
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet number of leading bytes from an AXI-Stream packet and re-aligns it MSB-first.
// Header side output is built only when STRIP_HDR_OUT_EN is defined.
module axi_stream_strip_header
    import axi_stream_strip_pkg::*;
#(
    parameter  int DATA_WD      = 32,
    localparam int DATA_BYTE_WD = DATA_WD / 8,
    localparam int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_strip,
    input  logic [LEN_WD-1:0]       len_strip,
    output logic                    ready_strip,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output state_e                  dbg_state_o
`ifdef STRIP_HDR_OUT_EN
    ,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_hdr
`endif
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the output register holds valid/data/keep/last unchanged until ready_out accepts them.
    logic [1:0]              state_q, state_d;
    logic [LEN_WD-1:0]       n_q, n_d;
    logic [LEN_WD-1:0]       flush_q, flush_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    out_free, acc, emit, emit_last;
    logic [DATA_WD-1:0]      emit_data, byte_mask, merged, next_res;
    logic [DATA_BYTE_WD-1:0] emit_keep;
    int                      k_in, r_bytes, emit_cnt;

    strip_byte_aligner #(.DATA_WD(DATA_WD), .LEN_WD(LEN_WD)) u_aligner (
        .residual_i      (res_q),
        .beat_i          (data_in),
        .len_i           (n_q),
        .merged_o        (merged),
        .next_residual_o (next_res)
    );

    always_comb begin
        out_free    = !valid_out_q || ready_out;
        ready_strip = !rst && (state_q == S_IDLE);
        ready_in    = !rst && (state_q == S_FIRST || state_q == S_BODY) && out_free;
        acc         = valid_in && ready_in;
        k_in        = keep_count(MAX_BYTES'(keep_in));
        r_bytes     = DATA_BYTE_WD - int'(n_q);

        state_d   = state_q;
        n_d       = n_q;
        res_d     = res_q;
        flush_d   = flush_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_data = '0;
        emit_cnt  = 0;

        case (state_q)
            S_IDLE: begin
                if (valid_strip && ready_strip) begin
                    n_d     = (len_strip > LEN_WD'(DATA_BYTE_WD)) ? LEN_WD'(DATA_BYTE_WD) : len_strip;
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                if (acc) begin
                    res_d = next_res;
                    if (last_in) begin
                        state_d = S_IDLE;
                        if (k_in > int'(n_q)) begin
                            emit      = 1'b1;
                            emit_data = next_res;
                            emit_cnt  = k_in - int'(n_q);
                            emit_last = 1'b1;
                        end
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (acc) begin
                    res_d     = next_res;
                    emit      = 1'b1;
                    emit_data = merged;
                    emit_cnt  = DATA_BYTE_WD;
                    if (last_in) begin
                        if (r_bytes + k_in <= DATA_BYTE_WD) begin
                            emit_cnt  = r_bytes + k_in;
                            emit_last = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            flush_d = LEN_WD'(r_bytes + k_in - DATA_BYTE_WD);
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            default: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_data = res_q;
                    emit_cnt  = int'(flush_q);
                    emit_last = 1'b1;
                    state_d   = S_IDLE;
                end
            end
        endcase

        emit_keep = DATA_BYTE_WD'(keep_from_count(emit_cnt, DATA_BYTE_WD));
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            byte_mask[i*8 +: 8] = {8{emit_keep[i]}};
        end

        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        if (out_free) begin
            valid_out_d = emit;
            if (emit) begin
                data_out_d = emit_data & byte_mask;
                keep_out_d = emit_keep;
                last_out_d = emit_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            flush_q     <= '0;
            res_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            flush_q     <= flush_d;
            res_q       <= res_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign keep_out    = keep_out_q;
    assign last_out    = last_out_q;
    assign dbg_state_o = state_e'(state_q);

`ifdef STRIP_HDR_OUT_EN
    logic                    valid_hdr_q, valid_hdr_d, hdr_cap;
    logic [DATA_WD-1:0]      header_q, header_d;
    logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

    always_comb begin
        hdr_cap     = (state_q == S_FIRST) && acc && (n_q != '0);
        valid_hdr_d = hdr_cap;
        header_d    = header_q;
        keep_hdr_d  = keep_hdr_q;
        if (hdr_cap) begin
            header_d   = data_in & ~({DATA_WD{1'b1}} >> (8 * int'(n_q)));
            keep_hdr_d = DATA_BYTE_WD'(keep_from_count(int'(n_q), DATA_BYTE_WD));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_hdr_q <= 1'b0;
            header_q    <= '0;
            keep_hdr_q  <= '0;
        end else begin
            valid_hdr_q <= valid_hdr_d;
            header_q    <= header_d;
            keep_hdr_q  <= keep_hdr_d;
        end
    end

    assign valid_hdr  = valid_hdr_q;
    assign header_out = header_q;
    assign keep_hdr   = keep_hdr_q;
`else
    // Header bytes are shifted out of the residual and simply dropped.
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed and randomized bench for axi_stream_strip_header against a byte-queue packet model.
module tb_axi_stream_strip_header;
    import axi_stream_strip_pkg::*;

    localparam int DATA_WD = 32;
    localparam int B       = DATA_WD / 8;
    localparam int LEN_WD  = $clog2(B + 1);
    localparam int EW      = DATA_WD + B + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic [DATA_WD-1:0] data_in = '0;
    logic [B-1:0]       keep_in = '0;
    logic               last_in = 1'b0;
    logic               ready_in;
    logic               valid_strip = 1'b0;
    logic [LEN_WD-1:0]  len_strip = '0;
    logic               ready_strip;
    logic               valid_out;
    logic [DATA_WD-1:0] data_out;
    logic [B-1:0]       keep_out;
    logic               last_out;
    logic               ready_out = 1'b1;
    state_e             dbg_state;
`ifdef STRIP_HDR_OUT_EN
    logic               valid_hdr;
    logic [DATA_WD-1:0] header_out;
    logic [B-1:0]       keep_hdr;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;
    int pat_idx  = 0;

    logic [EW-1:0]      exp_q[$];
    logic [EW-1:0]      obs_q[$];
    logic [DATA_WD-1:0] pkt_data[$];
    int                 pkt_k;

    logic               was_stalled = 1'b0;
    logic [EW-1:0]      held = '0;

    axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .keep_in     (keep_in),
        .last_in     (last_in),
        .ready_in    (ready_in),
        .valid_strip (valid_strip),
        .len_strip   (len_strip),
        .ready_strip (ready_strip),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .keep_out    (keep_out),
        .last_out    (last_out),
        .ready_out   (ready_out),
        .dbg_state_o (dbg_state)
`ifdef STRIP_HDR_OUT_EN
        ,
        .valid_hdr   (valid_hdr),
        .header_out  (header_out),
        .keep_hdr    (keep_hdr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: ready_out = 1'b1;
            1: ready_out = 1'($urandom_range(0, 1));
            2: begin
                ready_out = (pat_idx == 0 || pat_idx == 3);
                pat_idx   = (pat_idx + 1) % 4;
            end
            default: ready_out = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Output monitor: records accepted beats and checks that a stalled beat is held.
    always @(negedge clk) begin
        if (rst) begin
            was_stalled <= 1'b0;
        end else begin
            if (was_stalled)
                check("stall_hold", 64'({valid_out, data_out, keep_out, last_out}), 64'({1'b1, held}));
            if (valid_out && ready_out) obs_q.push_back({data_out, keep_out, last_out});
            was_stalled <= valid_out && !ready_out;
            held        <= {data_out, keep_out, last_out};
        end
    end

    function automatic logic [B-1:0] top_keep(input int c);
        logic [B-1:0] kp;
        kp = '0;
        for (int j = 0; j < c && j < B; j++) kp[B-1-j] = 1'b1;
        return kp;
    endfunction

    // Reference: flatten the packet's valid bytes, drop the first N, re-chunk into beats.
    task automatic model_packet(input int n);
        logic [7:0]         bq[$];
        logic [DATA_WD-1:0] d;
        int                 cnt, drop, c;
        for (int i = 0; i < pkt_data.size(); i++) begin
            d   = pkt_data[i];
            cnt = (i == pkt_data.size() - 1) ? pkt_k : B;
            for (int j = 0; j < cnt; j++) bq.push_back(d[DATA_WD-1-8*j -: 8]);
        end
        drop = (n > B) ? B : n;
        for (int j = 0; j < drop; j++) if (bq.size() > 0) void'(bq.pop_front());
        while (bq.size() > 0) begin
            d = '0;
            c = 0;
            while (c < B && bq.size() > 0) begin
                d[DATA_WD-1-8*c -: 8] = bq.pop_front();
                c++;
            end
            exp_q.push_back({d, top_keep(c), bq.size() == 0});
        end
    endtask

    task automatic send_packet(input int n, input int limit);
        int budget;
        valid_strip = 1'b1;
        len_strip   = LEN_WD'(n);
        budget = 0;
        do begin @(negedge clk); budget++; end while (!ready_strip && budget < 200);
        if (!ready_strip) timeout_fail("token_timeout");
        @(posedge clk); #1;
        valid_strip = 1'b0;
        for (int i = 0; i < limit; i++) begin
            valid_in = 1'b1;
            data_in  = pkt_data[i];
            last_in  = (i == pkt_data.size() - 1);
            keep_in  = last_in ? top_keep(pkt_k) : {B{1'b1}};
            budget = 0;
            do begin @(negedge clk); budget++; end while (!ready_in && budget < 500);
            if (!ready_in) timeout_fail("beat_timeout");
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        keep_in  = '0;
    endtask

    task automatic wait_and_compare(input string tag);
        int budget;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic void rand_packet(input int nbeats);
        pkt_data.delete();
        for (int i = 0; i < nbeats; i++) pkt_data.push_back($urandom);
        pkt_k = $urandom_range(1, B);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_keep_out", 64'(keep_out), 64'(0));
        check("rst_last_out", 64'(last_out), 64'(0));
        check("rst_ready_in", 64'(ready_in), 64'(0));
        check("rst_ready_strip", 64'(ready_strip), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
`ifdef STRIP_HDR_OUT_EN
        check("rst_hdr", 64'({valid_hdr, header_out, keep_hdr}), 64'(0));
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_strip", 64'(ready_strip), 64'(1));

        // N=0: pass-through delayed by one beat, tail takes the flush path.
        pkt_data = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1EEEE};
        pkt_k = 2;
        exp_q.push_back({32'hA0A1A2A3, 4'b1111, 1'b0});
        exp_q.push_back({32'hB0B1B2B3, 4'b1111, 1'b0});
        exp_q.push_back({32'hC0C10000, 4'b1100, 1'b1});
        send_packet(0, 3);
        wait_and_compare("n0");

        pkt_data = '{32'h11223344, 32'h55667788};
        pkt_k = 4;
        exp_q.push_back({32'h22334455, 4'b1111, 1'b0});
        exp_q.push_back({32'h66778800, 4'b1110, 1'b1});
        send_packet(1, 2);
        wait_and_compare("n1");

        pkt_data = '{32'h11223344, 32'h55ABCDEF};
        pkt_k = 1;
        exp_q.push_back({32'h44550000, 4'b1100, 1'b1});
        send_packet(3, 2);
        wait_and_compare("n3");

        // N=4 single beat vanishes entirely.
        pkt_data = '{32'hDEADBEEF};
        pkt_k = 4;
        send_packet(4, 1);
        check("n4_ready_strip", 64'(ready_strip), 64'(1));
`ifdef STRIP_HDR_OUT_EN
        check("n4_hdr", 64'({valid_hdr, header_out, keep_hdr}), 64'({1'b1, 32'hDEADBEEF, 4'b1111}));
`endif
        wait_and_compare("n4");

        pkt_data = '{32'h12345678};
        pkt_k = 4;
        model_packet(0);
        send_packet(0, 1);
        wait_and_compare("n0_after_n4");

        // N=2 six-beat packet with ready_out 1,0,0,1.
        rdy_mode = 2;
        rand_packet(6);
        model_packet(2);
        send_packet(2, 6);
        wait_and_compare("n2_stall");

        // Reset in the middle of BODY with an output beat pending.
        rdy_mode = 3;
        @(posedge clk); #1;
        rand_packet(4);
        send_packet(2, 2);
        check("pre_rst_valid_out", 64'(valid_out), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_outputs", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
        check("mid_rst_readies", 64'({ready_in, ready_strip}), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst = 1'b0;
        rdy_mode = 0;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rand_packet(3);
        model_packet(1);
        send_packet(1, 3);
        wait_and_compare("post_rst_n1");

        // Random packets, including clamped lengths above DATA_BYTE_WD.
        for (int p = 0; p < 40; p++) begin
            int n;
            rdy_mode = $urandom_range(0, 2);
            n = $urandom_range(0, (1 << LEN_WD) - 1);
            rand_packet($urandom_range(1, 5));
            model_packet(n);
            send_packet(n, pkt_data.size());
            wait_and_compare("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
